gbc_vram_arbiter: RTL

Shares the Game Boy Color video RAM (16 KiB, two 8 KiB banks) and OAM (160 B) block RAMs between the CPU memory bus and the PPU. It enforces mode-based CPU lockout: no CPU VRAM access in PPU mode 3, and no CPU OAM access in modes 2 and 3. It owns the VBK bank-select register (0xFF4F). It sits between the system memory bus decode and the VRAM/OAM BRAM ports, and every step is gated by the console clock-enable from CATC.

---
 rtl/gbc_vram_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gbc_vram_arbiter.sv
// Shares GBC VRAM/OAM block RAMs between the CPU bus and the PPU, with mode-based CPU lockout.
// Owns the VBK bank register. All state advances only on the console clock-enable.
module gbc_vram_arbiter #(
  parameter int unsigned OamBytes = 160
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ClkEn,
  input  logic        CgbMode,
  input  logic [1:0]  PpuMode,
  input  logic        CpuReq,
  input  logic        CpuWrite,
  input  logic [15:0] CpuAddr,
  input  logic [7:0]  CpuDataIn,
  output logic        CpuAck,
  output logic [7:0]  CpuDataOut,
  input  logic        PpuVramReq,
  input  logic [13:0] PpuVramAddr,
  input  logic        PpuOamReq,
  input  logic [7:0]  PpuOamAddr,
  output logic        PpuValid,
  output logic [7:0]  PpuData,
  output logic [13:0] VramAddr,
  output logic        VramRead,
  output logic        VramWrite,
  output logic [7:0]  VramWData,
  input  logic [7:0]  VramRData,
  output logic [7:0]  OamAddr,
  output logic        OamRead,
  output logic        OamWrite,
  output logic [7:0]  OamWData,
  input  logic [7:0]  OamRData,
  output logic        Bank
);

  localparam int unsigned OAM_LIM = OamBytes;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_DONE} state_e;
  typedef enum logic [1:0] {K_FF, K_VRAM, K_OAM, K_VBK} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        ack_q, ack_d;
  logic [7:0]  dout_q, dout_d;
  logic        bank_q, bank_d;
  logic        ppu_pend_q, ppu_pend_d;
  logic        ppu_sel_oam_q, ppu_sel_oam_d;
  logic        ppu_valid_q, ppu_valid_d;
  logic [7:0]  ppu_data_q, ppu_data_d;

  logic live, cpu_vram, cpu_oam, cpu_vbk, ppu_oam, conflict, vram_ok, oam_ok;

  // Address decode and lockout, evaluated every cycle but only acted on at acceptance.
  always_comb begin
    live     = ClkEn & ResetN;
    cpu_vram = (CpuAddr[15:13] == 3'b100);
    cpu_oam  = (CpuAddr[15:8] == 8'hFE);
    cpu_vbk  = (CpuAddr == 16'hFF4F);
    ppu_oam  = PpuOamReq & ~PpuVramReq;
    conflict = (cpu_vram & PpuVramReq) | (cpu_oam & ppu_oam);
    vram_ok  = cpu_vram & (PpuMode != 2'd3);
    oam_ok   = cpu_oam & ~PpuMode[1] & (32'(CpuAddr[7:0]) < OAM_LIM);
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    ack_d         = ack_q;
    dout_d        = dout_q;
    bank_d        = bank_q;
    ppu_pend_d    = ppu_pend_q;
    ppu_sel_oam_d = ppu_sel_oam_q;
    ppu_valid_d   = ppu_valid_q;
    ppu_data_d    = ppu_data_q;
    VramAddr      = 14'd0;
    VramRead      = 1'b0;
    VramWrite     = 1'b0;
    VramWData     = 8'd0;
    OamAddr       = 8'd0;
    OamRead       = 1'b0;
    OamWrite      = 1'b0;
    OamWData      = 8'd0;

    if (live) begin
      // PPU: strobe now, data one enabled cycle later.
      ppu_valid_d   = ppu_pend_q;
      if (ppu_pend_q) begin
        ppu_data_d = ppu_sel_oam_q ? OamRData : VramRData;
      end
      ppu_pend_d    = PpuVramReq | PpuOamReq;
      ppu_sel_oam_d = ~PpuVramReq;
      if (PpuVramReq) begin
        VramAddr = PpuVramAddr;
        VramRead = 1'b1;
      end else if (PpuOamReq) begin
        OamAddr = PpuOamAddr;
        OamRead = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (CpuReq && !conflict) begin
            state_d = S_RESP;
            kind_d  = K_FF;
            if (vram_ok) begin
              VramAddr  = {bank_q & CgbMode, CpuAddr[12:0]};
              VramRead  = ~CpuWrite;
              VramWrite = CpuWrite;
              VramWData = CpuWrite ? CpuDataIn : 8'd0;
            end
            if (oam_ok) begin
              OamAddr  = CpuAddr[7:0];
              OamRead  = ~CpuWrite;
              OamWrite = CpuWrite;
              OamWData = CpuWrite ? CpuDataIn : 8'd0;
            end
            if (CpuWrite) begin
              if (cpu_vbk && CgbMode) begin
                bank_d = CpuDataIn[0];
              end
            end else if (vram_ok) begin
              kind_d = K_VRAM;
            end else if (oam_ok) begin
              kind_d = K_OAM;
            end else if (cpu_vbk) begin
              kind_d = K_VBK;
            end
          end
        end
        S_RESP: begin
          ack_d   = 1'b1;
          state_d = S_DONE;
          case (kind_q)
            K_VRAM:  dout_d = VramRData;
            K_OAM:   dout_d = OamRData;
            K_VBK:   dout_d = {7'h7F, bank_q};
            default: dout_d = 8'hFF;
          endcase
        end
        S_DONE: begin
          ack_d = 1'b0;
          if (!CpuReq) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= S_IDLE;
      kind_q        <= K_FF;
      ack_q         <= 1'b0;
      dout_q        <= 8'd0;
      bank_q        <= 1'b0;
      ppu_pend_q    <= 1'b0;
      ppu_sel_oam_q <= 1'b0;
      ppu_valid_q   <= 1'b0;
      ppu_data_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      ack_q         <= ack_d;
      dout_q        <= dout_d;
      bank_q        <= bank_d;
      ppu_pend_q    <= ppu_pend_d;
      ppu_sel_oam_q <= ppu_sel_oam_d;
      ppu_valid_q   <= ppu_valid_d;
      ppu_data_q    <= ppu_data_d;
    end
  end

  assign CpuAck     = ack_q;
  assign CpuDataOut = dout_q;
  assign PpuValid   = ppu_valid_q;
  assign PpuData    = ppu_data_q;
  assign Bank       = bank_q;

endmodule
